// File: rtl/multichannel_block_storage_pkg.sv
// Shared types and derived constants for the multichannel hit-bit block storage.
package multichannel_block_storage_pkg;

    typedef enum logic [1:0] {
        ST_CLEAR   = 2'd0,
        ST_STORE   = 2'd1,
        ST_READOUT = 2'd2
    } state_t;

    localparam int DEF_ROWINDEXBITS = 4;
    localparam int DEF_COLINDEXBITS = 3;
    localparam int DEF_NCHANNELS    = 4;

    function automatic int pow2(input int bits);
        return 1 << bits;
    endfunction

    function automatic int nrows(input int rowbits);
        return pow2(rowbits);
    endfunction

    function automatic int rowwidth(input int colbits);
        return pow2(colbits);
    endfunction

    function automatic int addrbits(input int rowbits, input int colbits);
        return rowbits + colbits;
    endfunction

    localparam int NROWS    = nrows(DEF_ROWINDEXBITS);
    localparam int ROWWIDTH = rowwidth(DEF_COLINDEXBITS);
    localparam int ADDRBITS = addrbits(DEF_ROWINDEXBITS, DEF_COLINDEXBITS);

endpackage

// File: rtl/multichannel_block_storage_round_robin_arbiter.sv
// Round-robin grant across N requesters; search starts at the pointer and
// wraps, pointer moves past the winner only when the grant is accepted.
module round_robin_arbiter #(
    parameter int N = 4
) (
    input  logic         clock,
    input  logic         resetN,
    input  logic [N-1:0] req,
    input  logic         accept,
    output logic [N-1:0] grant
);

    localparam int PW = (N > 1) ? $clog2(N) : 1;

    logic [PW-1:0] ptr;
    logic [PW-1:0] gidx;
    logic          found;

    // First pass covers ptr..N-1, second pass the wrapped part 0..ptr-1.
    always_comb begin
        grant = '0;
        gidx  = '0;
        found = 1'b0;
        for (int k = 0; k < N; k++) begin
            if (!found && req[k] && (PW'(k) >= ptr)) begin
                found    = 1'b1;
                grant[k] = 1'b1;
                gidx     = PW'(k);
            end
        end
        for (int k = 0; k < N; k++) begin
            if (!found && req[k] && (PW'(k) < ptr)) begin
                found    = 1'b1;
                grant[k] = 1'b1;
                gidx     = PW'(k);
            end
        end
    end

    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            ptr <= '0;
        end else if (accept && found) begin
            ptr <= (gidx == PW'(N - 1)) ? '0 : gidx + 1'b1;
        end
    end

endmodule

// File: rtl/multichannel_block_storage.sv
// Bit-per-cell hit memory with round-robin multichannel writes, clear sweep and
// row readout stream. DUPLICATE_COUNT_EN adds a saturating duplicate-hit counter.
module multichannel_block_storage
    import multichannel_block_storage_pkg::*;
#(
    parameter int ROWINDEXBITS = DEF_ROWINDEXBITS,
    parameter int COLINDEXBITS = DEF_COLINDEXBITS,
    parameter int NCHANNELS    = DEF_NCHANNELS
) (
    input  logic                                           clock,
    input  logic                                           resetN,
    input  logic [NCHANNELS*(ROWINDEXBITS+COLINDEXBITS)-1:0] address,
    input  logic [NCHANNELS-1:0]                           newAddress,
    output logic [NCHANNELS-1:0]                           storageReady,
    input  logic                                           clearMemory,
    input  logic                                           readMemory,
    output logic [(2**COLINDEXBITS)-1:0]                   rowData,
    output logic [ROWINDEXBITS-1:0]                        rowIndex,
    output logic                                           readValid,
    input  logic                                           readReady,
    output logic                                           readDone,
    output logic                                           busy
`ifdef DUPLICATE_COUNT_EN
    ,
    output logic [15:0]                                    duplicateCount
`endif
);

    localparam int NROWS_P    = nrows(ROWINDEXBITS);
    localparam int ROWWIDTH_P = rowwidth(COLINDEXBITS);
    localparam int ADDRBITS_P = addrbits(ROWINDEXBITS, COLINDEXBITS);

    state_t state_q;
    state_t state_d;

    logic [ROWWIDTH_P-1:0]   mem [NROWS_P];
    logic [ROWINDEXBITS-1:0] clr_ptr;
    logic [ROWINDEXBITS-1:0] wr_row;
    logic [COLINDEXBITS-1:0] wr_col;
    logic [ROWINDEXBITS-1:0] next_row;
    logic [ADDRBITS_P-1:0]   sel_addr;
    logic [NCHANNELS-1:0]    grant;
    logic                    accept;
    logic                    last_row;
    logic                    row_taken;

    round_robin_arbiter #(
        .N (NCHANNELS)
    ) u_arb (
        .clock  (clock),
        .resetN (resetN),
        .req    (newAddress),
        .accept (accept),
        .grant  (grant)
    );

    assign storageReady = (state_q == ST_STORE) ? grant : '0;
    assign accept       = |(storageReady & newAddress);
    assign busy         = (state_q != ST_STORE);
    assign last_row     = (rowIndex == '1);
    assign next_row     = rowIndex + 1'b1;
    assign row_taken    = readValid && readReady;

    always_comb begin
        sel_addr = '0;
        for (int i = 0; i < NCHANNELS; i++) begin
            if (grant[i]) begin
                sel_addr = address[i*ADDRBITS_P +: ADDRBITS_P];
            end
        end
    end

    assign {wr_row, wr_col} = sel_addr;

    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            state_q <= ST_CLEAR;
        end else begin
            state_q <= state_d;
        end
    end

    // Clear request overrides every other transition, including readMemory.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_CLEAR: begin
                if (clr_ptr == '1) begin
                    state_d = ST_STORE;
                end
            end
            ST_STORE: begin
                if (readMemory) begin
                    state_d = ST_READOUT;
                end
            end
            ST_READOUT: begin
                if (row_taken && last_row) begin
                    state_d = ST_STORE;
                end
            end
            default: state_d = ST_CLEAR;
        endcase
        if (clearMemory) begin
            state_d = ST_CLEAR;
        end
    end

    always_ff @(posedge clock) begin
        if (state_q == ST_CLEAR) begin
            mem[clr_ptr] <= '0;
        end else if (accept) begin
            mem[wr_row][wr_col] <= 1'b1;
        end
    end

    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            clr_ptr   <= '0;
            rowData   <= '0;
            rowIndex  <= '0;
            readValid <= 1'b0;
            readDone  <= 1'b0;
        end else begin
            readDone <= 1'b0;
            if (clearMemory) begin
                clr_ptr   <= '0;
                readValid <= 1'b0;
            end else begin
                unique case (state_q)
                    ST_CLEAR: begin
                        clr_ptr <= clr_ptr + 1'b1;
                    end
                    ST_STORE: begin
                        if (readMemory) begin
                            rowIndex <= '0;
                        end
                    end
                    ST_READOUT: begin
                        // First READOUT cycle loads row 0; afterwards advance on handshake.
                        if (!readValid) begin
                            readValid <= 1'b1;
                            rowData   <= mem[rowIndex];
                        end else if (readReady) begin
                            if (last_row) begin
                                readValid <= 1'b0;
                                readDone  <= 1'b1;
                            end else begin
                                rowIndex <= next_row;
                                rowData  <= mem[next_row];
                            end
                        end
                    end
                    default: begin
                        readValid <= 1'b0;
                    end
                endcase
            end
        end
    end

`ifdef DUPLICATE_COUNT_EN
    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            duplicateCount <= '0;
        end else if (clearMemory || (state_q == ST_CLEAR)) begin
            duplicateCount <= '0;
        end else if (accept && mem[wr_row][wr_col] && (duplicateCount != 16'hFFFF)) begin
            duplicateCount <= duplicateCount + 16'd1;
        end
    end
`endif

endmodule
